// File: rtl/pio_responder_pkg.sv
// Shared constants for the AHB PIO responder: register offsets, AHB encodings
// and the data-phase FSM state type.
package pio_responder_pkg;

    localparam logic [4:0] REG_SYS_ID    = 5'h00;
    localparam logic [4:0] REG_BLD_ID    = 5'h04;
    localparam logic [4:0] REG_LED       = 5'h08;
    localparam logic [4:0] REG_RGB       = 5'h0C;
    localparam logic [4:0] REG_PB_IN     = 5'h10;
    localparam logic [4:0] REG_PB_EDGE   = 5'h14;
    localparam logic [4:0] REG_PB_IRQ_EN = 5'h18;
    localparam logic [4:0] REG_LAST      = REG_PB_IRQ_EN;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

endpackage

// File: rtl/pio_pb_sync_edge.sv
// Push-button synchronizer with rising-edge capture into sticky W1C flags.
// A new edge on a bit beats a simultaneous clear of that bit.
module pio_pb_sync_edge #(
    parameter int PB_W        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [PB_W-1:0] pb_i,
    input  logic [PB_W-1:0] clr_i,
    output logic [PB_W-1:0] pb_sync_o,
    output logic [PB_W-1:0] pb_edge_o
);

    logic [SYNC_STAGES-1:0][PB_W-1:0] sync_q;
    logic [PB_W-1:0]                  prev_q;
    logic [PB_W-1:0]                  edge_q;
    logic [PB_W-1:0]                  rise;

    assign pb_sync_o = sync_q[SYNC_STAGES-1];
    assign rise      = pb_sync_o & ~prev_q;
    assign pb_edge_o = edge_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= '0;
            edge_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pb_i};
            prev_q <= pb_sync_o;
            edge_q <= (edge_q & ~clr_i) | rise;
        end
    end

endmodule

// File: rtl/ahb_pio_responder.sv
// AHB-Lite responder for board PIO: LEDs, RGB LEDs, push-buttons with sticky
// edge flags and interrupt, and read-only ID words. Zero-wait OKAY, 2-cycle ERROR.
module ahb_pio_responder
    import pio_responder_pkg::*;
#(
    parameter int OFFS_W      = 12,
    parameter int PB_W        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            hsel,
    input  logic [1:0]      htrans,
    input  logic            hwrite,
    input  logic [2:0]      hsize,
    input  logic [31:0]     haddr,
    input  logic            hready_in,
    input  logic [31:0]     hwdata,
    output logic            hready_out,
    output logic            hresp,
    output logic [31:0]     hrdata,
    output logic [1:0]      pio_led_tri_o,
    output logic [11:0]     pio_led_rgb_tri_o,
    input  logic [PB_W-1:0] pio_pb_tri_i,
    output logic            pio_pb_irq,
    input  logic [31:0]     sys_id_tri_i,
    input  logic [31:0]     bld_id_tri_i
);

    state_e          state_q, state_d;
    logic [4:0]      offs_q;
    logic            wr_q;
    logic [1:0]      led_q;
    logic [11:0]     rgb_q;
    logic [PB_W-1:0] irq_en_q;
    logic            irq_q;
    logic [PB_W-1:0] pb_sync, pb_edge, pb_clr;
    logic            accept, legal, wr_en;
    logic            unused_bits;

    assign unused_bits = ^{haddr[31:OFFS_W], hwdata[31:12]};

    assign accept = hsel & hready_in & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
    assign legal  = (hsize == HSIZE_WORD) && (haddr[1:0] == 2'b00)
                 && (haddr[OFFS_W-1:5] == '0) && (haddr[4:0] <= REG_LAST);
    assign wr_en  = (state_q == ST_DATA) && wr_q;
    assign pb_clr = (wr_en && offs_q == REG_PB_EDGE) ? hwdata[PB_W-1:0] : '0;

    // ERR1 ignores the bus: hready_out is low, so no new address phase can be valid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = accept ? (legal ? ST_DATA : ST_ERR1) : ST_IDLE;
        endcase
    end

    always_comb begin
        hready_out = (state_q != ST_ERR1);
        hresp      = (state_q == ST_ERR1) || (state_q == ST_ERR2);
        hrdata     = '0;
        if (state_q == ST_DATA && !wr_q) begin
            case (offs_q)
                REG_SYS_ID:    hrdata = sys_id_tri_i;
                REG_BLD_ID:    hrdata = bld_id_tri_i;
                REG_LED:       hrdata = {30'd0, led_q};
                REG_RGB:       hrdata = {20'd0, rgb_q};
                REG_PB_IN:     hrdata = {{(32-PB_W){1'b0}}, pb_sync};
                REG_PB_EDGE:   hrdata = {{(32-PB_W){1'b0}}, pb_edge};
                REG_PB_IRQ_EN: hrdata = {{(32-PB_W){1'b0}}, irq_en_q};
                default:       hrdata = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            offs_q   <= '0;
            wr_q     <= 1'b0;
            led_q    <= '0;
            rgb_q    <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && legal && state_q != ST_ERR1) begin
                offs_q <= haddr[4:0];
                wr_q   <= hwrite;
            end
            if (wr_en) begin
                case (offs_q)
                    REG_LED:       led_q    <= hwdata[1:0];
                    REG_RGB:       rgb_q    <= hwdata[11:0];
                    REG_PB_IRQ_EN: irq_en_q <= hwdata[PB_W-1:0];
                    default:       ;
                endcase
            end
            irq_q <= |(pb_edge & irq_en_q);
        end
    end

    pio_pb_sync_edge #(
        .PB_W        (PB_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pb (
        .clk_i     (sys_clk),
        .rst_n_i   (sys_rst_n),
        .pb_i      (pio_pb_tri_i),
        .clr_i     (pb_clr),
        .pb_sync_o (pb_sync),
        .pb_edge_o (pb_edge)
    );

    assign pio_led_tri_o     = led_q;
    assign pio_led_rgb_tri_o = rgb_q;
    assign pio_pb_irq        = irq_q;

endmodule

// File: tb/tb_ahb_pio_responder.sv
// Directed bench for ahb_pio_responder; single responder on the bus, so
// hready_in is looped back from hready_out.
module tb_ahb_pio_responder;

    localparam logic [31:0] SYS_ID = 32'hC0DE_1234;
    localparam logic [31:0] BLD_ID = 32'h2024_0611;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        hsel, hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata;
    logic        hready_in, hready_out, hresp;
    logic [31:0] hrdata;
    logic [1:0]  pio_led_tri_o;
    logic [11:0] pio_led_rgb_tri_o;
    logic [3:0]  pio_pb_tri_i;
    logic        pio_pb_irq;
    logic [31:0] sys_id_tri_i, bld_id_tri_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;
    assign hready_in = hready_out;

    ahb_pio_responder dut (
        .sys_clk           (sys_clk),
        .sys_rst_n         (sys_rst_n),
        .hsel              (hsel),
        .htrans            (htrans),
        .hwrite            (hwrite),
        .hsize             (hsize),
        .haddr             (haddr),
        .hready_in         (hready_in),
        .hwdata            (hwdata),
        .hready_out        (hready_out),
        .hresp             (hresp),
        .hrdata            (hrdata),
        .pio_led_tri_o     (pio_led_tri_o),
        .pio_led_rgb_tri_o (pio_led_rgb_tri_o),
        .pio_pb_tri_i      (pio_pb_tri_i),
        .pio_pb_irq        (pio_pb_irq),
        .sys_id_tri_i      (sys_id_tri_i),
        .bld_id_tri_i      (bld_id_tri_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz;
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'b010;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        bus_idle();
        hwdata = '0;
        pio_pb_tri_i = '0;
        sys_id_tri_i = SYS_ID;
        bld_id_tri_i = BLD_ID;
        tick(); tick();

        chk("rst_hready", {31'd0, hready_out}, 32'd1);
        chk("rst_hresp", {31'd0, hresp}, 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_led", {30'd0, pio_led_tri_o}, 32'd0);
        chk("rst_rgb", {20'd0, pio_led_rgb_tri_o}, 32'd0);
        chk("rst_irq", {31'd0, pio_pb_irq}, 32'd0);
        sys_rst_n = 1'b1;
        tick();

        // ID reads, pipelined back to back
        addr_ph(32'h00, 1'b0, 3'b010); tick();
        chk("rd_sysid", hrdata, SYS_ID);
        chk("rd_sysid_rdy", {31'd0, hready_out}, 32'd1);
        chk("rd_sysid_resp", {31'd0, hresp}, 32'd0);
        addr_ph(32'h04, 1'b0, 3'b010); tick();
        chk("rd_bldid", hrdata, BLD_ID);
        bus_idle(); tick();
        chk("idle_hrdata", hrdata, 32'd0);

        // RGB write then immediate read-back; LED write with all-ones
        addr_ph(32'h0C, 1'b1, 3'b010); tick();
        hwdata = 32'h0000_0FFF;
        addr_ph(32'h0C, 1'b0, 3'b010); tick();
        chk("rgb_out", {20'd0, pio_led_rgb_tri_o}, 32'hFFF);
        chk("rgb_rd", hrdata, 32'h0000_0FFF);
        addr_ph(32'h08, 1'b1, 3'b010); tick();
        hwdata = 32'hFFFF_FFFF;
        chk("wr_dphase_hrdata", hrdata, 32'd0);
        addr_ph(32'h08, 1'b0, 3'b010); tick();
        chk("led_out", {30'd0, pio_led_tri_o}, 32'h3);
        chk("led_rd", hrdata, 32'h3);
        bus_idle(); tick();

        // Out-of-range read, then byte write issued during ERR2
        addr_ph(32'h1C, 1'b0, 3'b010); tick();
        chk("err1a_rdy", {31'd0, hready_out}, 32'd0);
        chk("err1a_resp", {31'd0, hresp}, 32'd1);
        bus_idle(); tick();
        chk("err2a_rdy", {31'd0, hready_out}, 32'd1);
        chk("err2a_resp", {31'd0, hresp}, 32'd1);
        addr_ph(32'h08, 1'b1, 3'b000); tick();
        chk("err1b_rdy", {31'd0, hready_out}, 32'd0);
        chk("err1b_resp", {31'd0, hresp}, 32'd1);
        hwdata = 32'h0;
        bus_idle(); tick();
        chk("err2b_rdy", {31'd0, hready_out}, 32'd1);
        chk("err2b_resp", {31'd0, hresp}, 32'd1);
        addr_ph(32'h08, 1'b0, 3'b010); tick();
        chk("post_err_rdy", {31'd0, hready_out}, 32'd1);
        chk("post_err_resp", {31'd0, hresp}, 32'd0);
        chk("post_err_led_rd", hrdata, 32'h3);
        chk("post_err_led", {30'd0, pio_led_tri_o}, 32'h3);
        bus_idle(); tick();

        // Misaligned word write is also an error and leaves RGB alone
        addr_ph(32'h0E, 1'b1, 3'b010); tick();
        chk("misalign_resp", {31'd0, hresp}, 32'd1);
        hwdata = 32'h0;
        bus_idle(); tick(); tick();
        chk("misalign_rgb", {20'd0, pio_led_rgb_tri_o}, 32'hFFF);

        // Enable irq for button 2, then pulse it for 3 cycles
        addr_ph(32'h18, 1'b1, 3'b010); tick();
        hwdata = 32'h4;
        bus_idle(); tick();
        pio_pb_tri_i = 4'b0100;
        tick();                                    // edge 1
        addr_ph(32'h14, 1'b0, 3'b010); tick();     // edge 2
        chk("pb_edge_early", hrdata, 32'h0);
        addr_ph(32'h14, 1'b0, 3'b010); tick();     // edge 3
        chk("pb_edge_set", hrdata, 32'h4);
        chk("irq_not_yet", {31'd0, pio_pb_irq}, 32'd0);
        pio_pb_tri_i = 4'b0000;
        addr_ph(32'h10, 1'b0, 3'b010); tick();     // edge 4
        chk("irq_set", {31'd0, pio_pb_irq}, 32'd1);
        chk("pb_in", hrdata, 32'h4);
        addr_ph(32'h14, 1'b1, 3'b010); tick();
        hwdata = 32'h4;
        addr_ph(32'h14, 1'b0, 3'b010); tick();
        chk("pb_edge_clr", hrdata, 32'h0);
        chk("irq_lag", {31'd0, pio_pb_irq}, 32'd1);
        bus_idle(); tick();
        chk("irq_clr", {31'd0, pio_pb_irq}, 32'd0);

        // Clear of bit 0 in the same cycle its new edge is seen: set wins
        pio_pb_tri_i = 4'b0001;
        tick();
        addr_ph(32'h14, 1'b1, 3'b010); tick();
        hwdata = 32'h1;
        bus_idle(); tick();
        addr_ph(32'h14, 1'b0, 3'b010); tick();
        chk("set_wins", hrdata, 32'h1);
        chk("irq_masked", {31'd0, pio_pb_irq}, 32'd0);
        pio_pb_tri_i = 4'b0000;
        bus_idle(); tick();

        // Reset asserted during ERR1
        addr_ph(32'h20, 1'b0, 3'b010); tick();
        chk("err1c_rdy", {31'd0, hready_out}, 32'd0);
        bus_idle();
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_err_rdy", {31'd0, hready_out}, 32'd1);
        chk("rst_err_resp", {31'd0, hresp}, 32'd0);
        chk("rst_err_led", {30'd0, pio_led_tri_o}, 32'd0);
        chk("rst_err_rgb", {20'd0, pio_led_rgb_tri_o}, 32'd0);
        tick();
        sys_rst_n = 1'b1;
        tick();
        addr_ph(32'h18, 1'b0, 3'b010); tick();
        chk("rst_irqen_rd", hrdata, 32'h0);
        addr_ph(32'h14, 1'b0, 3'b010); tick();
        chk("rst_edge_rd", hrdata, 32'h0);
        bus_idle(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_pio_responder.md
# ahb_pio_responder

AHB-Lite responder (slave) for the SCR1 data-memory AHB port, holding the board's programmable I/O: discrete LEDs, RGB LEDs, push-buttons with sticky edge capture and interrupt, and read-only system/build ID words. It sits behind the `system` interconnect's D-Mem path as the target end of the core's AHB initiator. Its `pio_pb_irq` output feeds the SCR1 IRQ line vector.

## Interface
- `OFFS_W`, 12: decoded byte-offset bits of `haddr`; the window is 4 KiB.
- `PB_W`, 4: push-button count.
- `SYNC_STAGES`, 2: synchronizer depth for button inputs, minimum 2.
- `sys_clk` in 1: single clock, all logic rising-edge.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `hsel` in 1: slave select.
- `htrans` in 2: AHB transfer type; only NONSEQ/SEQ (bit 1 = 1) start transfers.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: transfer size; only 3'b010 (word) is legal.
- `haddr` in 32: address; only `[OFFS_W-1:0]` is decoded.
- `hready_in` in 1: bus HREADY.
- `hwdata` in 32: write data, data phase.
- `hready_out` out 1: this slave's HREADYOUT.
- `hresp` out 1: 0 = OKAY, 1 = ERROR.
- `hrdata` out 32: read data.
- `pio_led_tri_o` out 2: LED register.
- `pio_led_rgb_tri_o` out 12: RGB LED register.
- `pio_pb_tri_i` in PB_W: raw buttons, asynchronous.
- `pio_pb_irq` out 1: registered interrupt, active-high level.
- `sys_id_tri_i`, `bld_id_tri_i` in 32: static ID words.

## Operation
- Address phase accepted when `hsel & htrans[1] & hready_in`. Offset, write flag and legality are captured into data-phase registers.
- Register map (word offsets):
  - 0x00 SYS_ID, RO.
  - 0x04 BLD_ID, RO.
  - 0x08 LED[1:0], RW.
  - 0x0C RGB[11:0], RW.
  - 0x10 PB_IN, RO: synchronized button levels.
  - 0x14 PB_EDGE, W1C: sticky rising-edge flags.
  - 0x18 PB_IRQ_EN, RW.
- Unused bits read 0. Writes to RO registers are ignored and respond OKAY.
- Illegal transfers respond ERROR with no register side effect. Illegal means: `hsize` ≠ word, `haddr[1:0]` ≠ 0, or offset > 0x18.
- Data-phase FSM:
  - IDLE→DATA on a legal accept; IDLE→ERR1 on an illegal accept.
  - DATA→DATA / ERR1 / IDLE on the next accept, illegal accept, or none.
  - ERR1→ERR2 unconditionally.
  - ERR2 behaves as IDLE for accepts, since `hready_in` is high in ERR2.
- Write data is taken from `hwdata` in the DATA cycle and registered at the clock edge ending that cycle.
- Button path: SYNC_STAGES-flop synchronizer, then a previous-value register.
  - edge = synced & ~prev sets PB_EDGE bits.
  - A W1C write clears the bits written as 1.
  - If set and clear hit the same bit in the same cycle, set wins.
- `pio_pb_irq` <= |(PB_EDGE & PB_IRQ_EN), one register stage.

## Timing
- Reset values:
  - `hready_out`=1, `hresp`=0, `hrdata`=0.
  - LED=0, RGB=0, PB_EDGE=0, PB_IRQ_EN=0, `pio_pb_irq`=0.
  - Synchronizer and prev registers=0; FSM=IDLE.
- OKAY transfers have zero wait states: `hready_out`=1 and `hresp`=0 in DATA.
- Read data is valid in the DATA cycle, decoded from the registered offset against current register contents.
- Write→read of the same register back-to-back returns the new value.
- `hrdata`=0 outside read DATA cycles.
- ERROR response is two cycles:
  - ERR1: `hready_out`=0, `hresp`=1.
  - ERR2: `hready_out`=1, `hresp`=1.
- Button press to PB_EDGE set: SYNC_STAGES+1 cycles. PB_EDGE set to `pio_pb_irq` high: +1 cycle.
- Reset asserted mid-transfer or mid-ERROR returns immediately to reset values. No transfer completes.

## Structure
- Package `pio_responder_pkg`: register offset constants, the FSM state enum (IDLE, DATA, ERR1, ERR2), and the HTRANS/HSIZE constants.
- One sub-module, `pio_pb_sync_edge`: synchronizer, edge detect and sticky W1C flags, parameterized by PB_W and SYNC_STAGES.

## Test plan
- Reset, then read 0x00 and 0x04 → `sys_id_tri_i` and `bld_id_tri_i` values, OKAY, zero waits. All outputs at reset values.
- Write 0x0C=0xFFF, then back-to-back read of 0x0C → `pio_led_rgb_tri_o`=0xFFF and `hrdata`=0x00000FFF. Write 0x08=0xFFFFFFFF → LED=2'b11, readback 0x3.
- Read 0x1C, then a byte write to 0x08 → each gives ERR1 (`hready_out` 0, `hresp` 1) then ERR2 (1, 1). LED unchanged. A transfer issued in ERR2 completes OKAY.
- Pulse button 2 high for 3 cycles with PB_IRQ_EN=0x4 → PB_EDGE=0x4 after 3 cycles, `pio_pb_irq`=1 one cycle later. Write 0x14=0x4 → PB_EDGE=0, irq low one cycle later.
- W1C of bit 0 in the same cycle as a new bit-0 edge → PB_EDGE[0] stays 1.
- Assert `sys_rst_n` during ERR1 → `hready_out`=1, `hresp`=0 immediately. All registers zero.
